// File: rtl/iaram_stream_writer.sv
// PE-side activation stream receiver: packs multi-lane data/index beats into per-channel
// IARAM banks, tracks counts and dense mode, then serves a registered read port once READY.
module iaram_stream_writer #(
  parameter  int LANES    = 4,
  parameter  int DATA_W   = 16,
  parameter  int IDX_W    = 4,
  parameter  int CHANNELS = 3,
  parameter  int DEPTH    = 64,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int LW       = $clog2(LANES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES-1:0]           in_data_valid_i,
  input  logic [LANES*DATA_W-1:0]    in_data_i,
  input  logic                       in_dense_i,
  input  logic [CH_W-1:0]            in_data_ch_i,
  input  logic [LANES-1:0]           in_idx_valid_i,
  input  logic [LANES*IDX_W-1:0]     in_idx_i,
  input  logic [CH_W-1:0]            in_idx_ch_i,
  input  logic                       stream_done_i,
  input  logic                       clr_i,
  input  logic                       rd_en_i,
  input  logic [CH_W-1:0]            rd_ch_i,
  input  logic [AW-1:0]              rd_addr_i,
  output logic                       rd_valid_o,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic [IDX_W-1:0]           rd_idx_o,
  output logic                       buf_ready_o,
  output logic [CHANNELS*CW-1:0]     data_cnt_o,
  output logic [CHANNELS*CW-1:0]     idx_cnt_o,
  output logic [CHANNELS-1:0]        ch_dense_o,
  output logic                       overflow_o,
  output logic                       proto_err_o
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FILL = 2'd1, ST_READY = 2'd2} state_e;

  // A valid pattern is a prefix when adding one to it clears every set bit.
  function automatic logic lanes_prefix(input logic [LANES-1:0] v);
    return (v & (v + LANES'(1))) == '0;
  endfunction

  function automatic logic [LW-1:0] lanes_count(input logic [LANES-1:0] v);
    logic [LW-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + LW'(v[i]);
    return n;
  endfunction

  state_e              state_q, state_d;
  logic [CW-1:0]       data_ptr_q [CHANNELS];
  logic [CW-1:0]       data_ptr_d [CHANNELS];
  logic [CW-1:0]       idx_ptr_q  [CHANNELS];
  logic [CW-1:0]       idx_ptr_d  [CHANNELS];
  logic [CHANNELS-1:0] dense_q, dense_d;
  logic                overflow_q, overflow_d, proto_err_q, proto_err_d, buf_ready_q;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [IDX_W-1:0]    rd_idx_q;

  logic [DATA_W-1:0]   data_mem [CHANNELS][DEPTH];
  logic [IDX_W-1:0]    idx_mem  [CHANNELS][DEPTH];

  logic                d_any, i_any, d_ok, i_ok, d_we, i_we, rd_ok, rd_ch_ok;
  logic [CH_W-1:0]     d_ch, i_ch, rd_c;
  logic [CW-1:0]       d_sum, i_sum;

  assign d_any    = |in_data_valid_i;
  assign i_any    = |in_idx_valid_i;
  assign d_ch     = (int'(in_data_ch_i) < CHANNELS) ? in_data_ch_i : '0;
  assign i_ch     = (int'(in_idx_ch_i) < CHANNELS) ? in_idx_ch_i : '0;
  assign d_ok     = lanes_prefix(in_data_valid_i) && (int'(in_data_ch_i) < CHANNELS);
  assign i_ok     = lanes_prefix(in_idx_valid_i) && (int'(in_idx_ch_i) < CHANNELS);
  assign d_sum    = data_ptr_q[d_ch] + CW'(lanes_count(in_data_valid_i));
  assign i_sum    = idx_ptr_q[i_ch] + CW'(lanes_count(in_idx_valid_i));
  assign rd_ch_ok = int'(rd_ch_i) < CHANNELS;
  assign rd_c     = rd_ch_ok ? rd_ch_i : '0;
  assign rd_ok    = rd_en_i && (state_q == ST_READY) && !clr_i;

  // Next-state: clr dominates, READY rejects beats, otherwise accept and saturate pointers.
  always_comb begin
    state_d     = state_q;
    data_ptr_d  = data_ptr_q;
    idx_ptr_d   = idx_ptr_q;
    dense_d     = dense_q;
    overflow_d  = overflow_q;
    proto_err_d = proto_err_q;
    d_we        = 1'b0;
    i_we        = 1'b0;
    if (clr_i) begin
      state_d = ST_IDLE;
      for (int c = 0; c < CHANNELS; c++) begin
        data_ptr_d[c] = '0;
        idx_ptr_d[c]  = '0;
      end
      dense_d     = '0;
      overflow_d  = 1'b0;
      proto_err_d = 1'b0;
    end else if (state_q == ST_READY) begin
      proto_err_d = proto_err_q | d_any | i_any;
    end else begin
      if (d_any && d_ok) begin
        d_we = 1'b1;
        if (data_ptr_q[d_ch] == '0) dense_d[d_ch] = in_dense_i;
        else proto_err_d = proto_err_d | (dense_q[d_ch] != in_dense_i);
        if (d_sum > CW'(DEPTH)) begin
          data_ptr_d[d_ch] = CW'(DEPTH);
          overflow_d       = 1'b1;
        end else begin
          data_ptr_d[d_ch] = d_sum;
        end
      end else begin
        proto_err_d = proto_err_d | d_any;
      end
      if (i_any && i_ok) begin
        i_we = 1'b1;
        if (i_sum > CW'(DEPTH)) begin
          idx_ptr_d[i_ch] = CW'(DEPTH);
          overflow_d      = 1'b1;
        end else begin
          idx_ptr_d[i_ch] = i_sum;
        end
      end else begin
        proto_err_d = proto_err_d | i_any;
      end
      // The index check sees this cycle's beats, which land before READY.
      if (stream_done_i) begin
        state_d = ST_READY;
        for (int c = 0; c < CHANNELS; c++)
          proto_err_d = proto_err_d | (dense_d[c] ? (idx_ptr_d[c] != '0)
                                                  : (idx_ptr_d[c] != data_ptr_d[c]));
      end else if (d_any || i_any) begin
        state_d = ST_FILL;
      end else begin
        state_d = state_q;
      end
    end
  end

  // Control and read-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      for (int c = 0; c < CHANNELS; c++) begin
        data_ptr_q[c] <= '0;
        idx_ptr_q[c]  <= '0;
      end
      dense_q     <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
      buf_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      data_ptr_q  <= data_ptr_d;
      idx_ptr_q   <= idx_ptr_d;
      dense_q     <= dense_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
      buf_ready_q <= (state_d == ST_READY);
      rd_valid_q  <= rd_ok;
      if (rd_ok) begin
        rd_data_q <= (rd_ch_ok && (CW'(rd_addr_i) < data_ptr_q[rd_c])) ? data_mem[rd_c][rd_addr_i] : '0;
        rd_idx_q  <= (rd_ch_ok && (CW'(rd_addr_i) < idx_ptr_q[rd_c])) ? idx_mem[rd_c][rd_addr_i] : '0;
      end
    end
  end

  // Storage has no reset; lanes past the end of a channel are simply not written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (d_we && in_data_valid_i[i] && ((data_ptr_q[d_ch] + CW'(i)) < CW'(DEPTH)))
        data_mem[d_ch][AW'(data_ptr_q[d_ch] + CW'(i))] <= in_data_i[i*DATA_W +: DATA_W];
      if (i_we && in_idx_valid_i[i] && ((idx_ptr_q[i_ch] + CW'(i)) < CW'(DEPTH)))
        idx_mem[i_ch][AW'(idx_ptr_q[i_ch] + CW'(i))] <= in_idx_i[i*IDX_W +: IDX_W];
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_cnt
    assign data_cnt_o[c*CW +: CW] = data_ptr_q[c];
    assign idx_cnt_o[c*CW +: CW]  = idx_ptr_q[c];
  end

  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_idx_o    = rd_idx_q;
  assign buf_ready_o = buf_ready_q;
  assign ch_dense_o  = dense_q;
  assign overflow_o  = overflow_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_iaram_stream_writer.sv
// Bench for iaram_stream_writer: directed scenarios plus randomized streams, all checked
// against a per-channel array model built from the stream rules.
module tb_iaram_stream_writer;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dv, iv;
  logic [63:0] dd;
  logic [15:0] id;
  logic        dn, done, clr, rd_en;
  logic [1:0]  dch, ich, rd_ch;
  logic [5:0]  rd_addr;
  logic        rd_valid, buf_ready, overflow, proto_err;
  logic [15:0] rd_data;
  logic [3:0]  rd_idx;
  logic [20:0] data_cnt, idx_cnt;
  logic [2:0]  ch_dense;

  iaram_stream_writer dut (
    .clk(clk), .rst(rst),
    .in_data_valid_i(dv), .in_data_i(dd), .in_dense_i(dn), .in_data_ch_i(dch),
    .in_idx_valid_i(iv), .in_idx_i(id), .in_idx_ch_i(ich),
    .stream_done_i(done), .clr_i(clr),
    .rd_en_i(rd_en), .rd_ch_i(rd_ch), .rd_addr_i(rd_addr),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_idx_o(rd_idx),
    .buf_ready_o(buf_ready), .data_cnt_o(data_cnt), .idx_cnt_o(idx_cnt),
    .ch_dense_o(ch_dense), .overflow_o(overflow), .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: per-channel stored entries and counts.
  logic [15:0] m_d [3][DEPTH];
  logic [3:0]  m_i [3][DEPTH];
  int          m_dc [3];
  int          m_ic [3];
  bit          m_seen [3];
  bit          m_dense [3];
  bit          m_ready, m_ovf, m_perr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    for (int c = 0; c < 3; c++) begin
      m_dc[c] = 0; m_ic[c] = 0; m_seen[c] = 1'b0; m_dense[c] = 1'b0;
    end
    m_ready = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
  endtask

  function automatic bit prefix_ok(input logic [3:0] v);
    bit gap = 1'b0;
    for (int l = 0; l < 4; l++) begin
      if (!v[l]) gap = 1'b1;
      else if (gap) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_data(input logic [3:0] v, input logic [63:0] d, input bit dns, input int c);
    if (v == 4'd0) return;
    if (m_ready || !prefix_ok(v)) begin m_perr = 1'b1; return; end
    if (!m_seen[c]) begin m_seen[c] = 1'b1; m_dense[c] = dns; end
    else if (m_dense[c] != dns) m_perr = 1'b1;
    for (int l = 0; l < 4; l++)
      if (v[l]) begin
        if (m_dc[c] < DEPTH) begin m_d[c][m_dc[c]] = d[l*16 +: 16]; m_dc[c]++; end
        else m_ovf = 1'b1;
      end
  endtask

  task automatic m_idx(input logic [3:0] v, input logic [15:0] x, input int c);
    if (v == 4'd0) return;
    if (m_ready || !prefix_ok(v)) begin m_perr = 1'b1; return; end
    for (int l = 0; l < 4; l++)
      if (v[l]) begin
        if (m_ic[c] < DEPTH) begin m_i[c][m_ic[c]] = x[l*4 +: 4]; m_ic[c]++; end
        else m_ovf = 1'b1;
      end
  endtask

  task automatic m_done();
    if (m_ready) return;
    for (int c = 0; c < 3; c++)
      if (m_dense[c] ? (m_ic[c] != 0) : (m_ic[c] != m_dc[c])) m_perr = 1'b1;
    m_ready = 1'b1;
  endtask

  task automatic check_state(input string tag);
    logic [20:0] edc, eic;
    logic [2:0]  edn;
    for (int c = 0; c < 3; c++) begin
      edc[c*7 +: 7] = 7'(m_dc[c]);
      eic[c*7 +: 7] = 7'(m_ic[c]);
      edn[c]        = m_dense[c];
    end
    check({tag, "_ready"}, buf_ready, m_ready);
    check({tag, "_ovf"}, overflow, m_ovf);
    check({tag, "_perr"}, proto_err, m_perr);
    check({tag, "_dense"}, ch_dense, edn);
    check({tag, "_dcnt"}, data_cnt, edc);
    check({tag, "_icnt"}, idx_cnt, eic);
    check({tag, "_rdv"}, rd_valid, 1'b0);
  endtask

  task automatic cyc(input logic [3:0] v_d, input logic [63:0] d, input bit dns, input int c_d,
                     input logic [3:0] v_i, input logic [15:0] x, input int c_i,
                     input bit sd, input bit cl);
    dv = v_d; dd = d; dn = dns; dch = 2'(c_d);
    iv = v_i; id = x; ich = 2'(c_i); done = sd; clr = cl;
    if (cl) m_clear();
    else begin
      m_data(v_d, d, dns, c_d);
      m_idx(v_i, x, c_i);
      if (sd) m_done();
    end
    @(posedge clk); #1;
    dv = 4'd0; iv = 4'd0; done = 1'b0; clr = 1'b0;
    check_state("cyc");
  endtask

  task automatic rd(input int c, input int a);
    bit exp_v;
    exp_v = m_ready;
    rd_en = 1'b1; rd_ch = 2'(c); rd_addr = 6'(a);
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("rd_valid", rd_valid, exp_v);
    if (exp_v) begin
      check("rd_data", rd_data, (a < m_dc[c]) ? m_d[c][a] : 16'd0);
      check("rd_idx", rd_idx, (a < m_ic[c]) ? m_i[c][a] : 4'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; m_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    check_state("rst");
    check("rst_rdata", rd_data, 16'd0);
    check("rst_ridx", rd_idx, 4'd0);
  endtask

  function automatic logic [63:0] seq16(input int s);
    return {16'(s + 3), 16'(s + 2), 16'(s + 1), 16'(s)};
  endfunction

  function automatic logic [15:0] seq4(input int s);
    return {4'(s + 3), 4'(s + 2), 4'(s + 1), 4'(s)};
  endfunction

  function automatic logic [3:0] rmask();
    if ($urandom_range(0, 9) == 0) return 4'($urandom);
    return 4'((1 << $urandom_range(0, 4)) - 1);
  endfunction

  initial begin
    rst = 1'b1; dv = 4'd0; iv = 4'd0; dd = 64'd0; id = 16'd0; dn = 1'b0;
    dch = 2'd0; ich = 2'd0; done = 1'b0; clr = 1'b0; rd_en = 1'b0; rd_ch = 2'd0; rd_addr = 6'd0;
    m_clear();
    @(posedge clk); #1;
    do_reset();

    // Compressed channel 0: 4+4+2 lanes.
    cyc(4'hf, seq16(1), 1'b0, 0, 4'hf, seq4(0), 0, 1'b0, 1'b0);
    cyc(4'hf, seq16(5), 1'b0, 0, 4'hf, seq4(4), 0, 1'b0, 1'b0);
    cyc(4'h3, seq16(9), 1'b0, 0, 4'h3, seq4(8), 0, 1'b0, 1'b0);
    cyc(4'h0, 64'd0, 1'b0, 0, 4'h0, 16'd0, 0, 1'b1, 1'b0);
    check("t1_dcnt", data_cnt[6:0], 7'd10);
    check("t1_icnt", idx_cnt[6:0], 7'd10);
    check("t1_ready", buf_ready, 1'b1);
    check("t1_perr", proto_err, 1'b0);
    rd(0, 9);
    check("t1_rdata", rd_data, 16'd10);
    check("t1_ridx", rd_idx, 4'd9);

    // Mixed channels.
    cyc(4'h0, 64'd0, 1'b0, 0, 4'h0, 16'd0, 0, 1'b0, 1'b1);
    cyc(4'hf, seq16(100), 1'b0, 0, 4'hf, seq4(0), 0, 1'b0, 1'b0);
    cyc(4'h1, seq16(104), 1'b0, 0, 4'h1, seq4(4), 0, 1'b0, 1'b0);
    cyc(4'hf, seq16(300), 1'b1, 1, 4'h0, 16'd0, 0, 1'b0, 1'b0);
    cyc(4'hf, seq16(304), 1'b1, 1, 4'h0, 16'd0, 0, 1'b0, 1'b0);
    cyc(4'h7, seq16(200), 1'b0, 2, 4'h7, seq4(1), 2, 1'b1, 1'b0);
    check("t2_cnts", data_cnt, {7'd3, 7'd8, 7'd5});
    check("t2_dense", ch_dense, 3'b010);
    check("t2_perr", proto_err, 1'b0);
    rd(1, 7); rd(2, 2); rd(2, 3);

    // Overflow on a dense channel 0.
    cyc(4'h0, 64'd0, 1'b0, 0, 4'h0, 16'd0, 0, 1'b0, 1'b1);
    for (int b = 0; b < 15; b++) cyc(4'hf, seq16(b * 4), 1'b1, 0, 4'h0, 16'd0, 0, 1'b0, 1'b0);
    cyc(4'h3, seq16(60), 1'b1, 0, 4'h0, 16'd0, 0, 1'b0, 1'b0);
    cyc(4'hf, {16'hd0d0, 16'hc0c0, 16'hb0b0, 16'ha0a0}, 1'b1, 0, 4'h0, 16'd0, 0, 1'b1, 1'b0);
    check("t3_dcnt", data_cnt[6:0], 7'd64);
    check("t3_ovf", overflow, 1'b1);
    rd(0, 63);
    check("t3_rd63", rd_data, 16'hb0b0);
    rd(0, 62);
    check("t3_rd62", rd_data, 16'ha0a0);

    // Protocol errors.
    cyc(4'h0, 64'd0, 1'b0, 0, 4'h0, 16'd0, 0, 1'b0, 1'b1);
    cyc(4'b0101, seq16(7), 1'b0, 0, 4'h0, 16'd0, 0, 1'b0, 1'b0);
    check("t4_gap_perr", proto_err, 1'b1);
    check("t4_gap_cnt", data_cnt[6:0], 7'd0);
    cyc(4'h0, 64'd0, 1'b0, 0, 4'h0, 16'd0, 0, 1'b0, 1'b1);
    cyc(4'h1, seq16(1), 1'b0, 1, 4'h1, seq4(1), 1, 1'b1, 1'b0);
    cyc(4'h1, seq16(2), 1'b0, 1, 4'h0, 16'd0, 0, 1'b0, 1'b0);
    check("t4_ready_perr", proto_err, 1'b1);
    cyc(4'h0, 64'd0, 1'b0, 0, 4'h0, 16'd0, 0, 1'b0, 1'b1);
    cyc(4'hf, seq16(1), 1'b0, 0, 4'hf, seq4(0), 0, 1'b0, 1'b0);
    cyc(4'h3, seq16(5), 1'b0, 0, 4'h1, seq4(4), 0, 1'b1, 1'b0);
    check("t4_cnt_perr", proto_err, 1'b1);

    // Done coincident with a final beat, clr in READY, reads in IDLE, rst mid-fill.
    cyc(4'h0, 64'd0, 1'b0, 0, 4'h0, 16'd0, 0, 1'b0, 1'b1);
    cyc(4'hf, seq16(40), 1'b1, 2, 4'h0, 16'd0, 0, 1'b0, 1'b0);
    cyc(4'h3, seq16(44), 1'b1, 2, 4'h0, 16'd0, 0, 1'b1, 1'b0);
    check("t5_cnt", data_cnt[20:14], 7'd6);
    check("t5_ready", buf_ready, 1'b1);
    rd(2, 5);
    cyc(4'h0, 64'd0, 1'b0, 0, 4'h0, 16'd0, 0, 1'b0, 1'b1);
    check("t5_clr_cnt", data_cnt, 21'd0);
    check("t5_clr_ready", buf_ready, 1'b0);
    rd(2, 0);
    check("t5_idle_rdv", rd_valid, 1'b0);
    cyc(4'h7, seq16(9), 1'b0, 1, 4'h3, seq4(2), 1, 1'b0, 1'b0);
    do_reset();

    // Randomized streams.
    for (int r = 0; r < 24; r++) begin
      bit dmode [3];
      int nb, cd, ci, a;
      logic [3:0] vd, vi;
      bit dns, sd;
      for (int c = 0; c < 3; c++) dmode[c] = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 40);
      cyc(4'h0, 64'd0, 1'b0, 0, 4'h0, 16'd0, 0, 1'b0, 1'b1);
      sd = 1'b0;
      for (int b = 0; b < nb; b++) begin
        cd = $urandom_range(0, 2);
        vd = rmask();
        sd = (b == nb - 1) && ($urandom_range(0, 1) == 1);
        if (r % 2 == 0) begin
          ci = cd; dns = dmode[cd]; vi = dmode[cd] ? 4'h0 : vd;
        end else begin
          ci = $urandom_range(0, 2); vi = rmask();
          dns = dmode[cd] ^ ($urandom_range(0, 9) == 0);
        end
        cyc(vd, {$urandom, $urandom}, dns, cd, vi, 16'($urandom), ci, sd, 1'b0);
      end
      if (!sd) cyc(4'h0, 64'd0, 1'b0, 0, 4'h0, 16'd0, 0, 1'b1, 1'b0);
      if (r % 3 == 0) cyc(rmask(), {$urandom, $urandom}, 1'b0, 0, 4'h1, 16'd3, 1, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
        cd = $urandom_range(0, 2);
        a = (m_dc[cd] > 0 && $urandom_range(0, 2) != 0) ? $urandom_range(0, m_dc[cd] - 1)
                                                        : $urandom_range(0, DEPTH - 1);
        rd(cd, a);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
